// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Pipeline hazard unit that sits beside the D stage. It uses a
//            per-register countdown scoreboard, loaded when an instruction
//            issues from D to E, to detect operand hazards. A cycle counter
//            tracks when the HI/LO multiply/divide unit is busy. A
//            three-state FSM sequences pipeline flushes for exceptions.
// Optional : define HAZARD_PERF_EN to build the stall-cycle perf counters.
//            When it is undefined, the perf outputs are tied to zero.
// Ports    : clk, resetn (async active-low)
//            d_valid, d_rs/d_rt, d_use_rs/d_use_rt, d_is_branch  - D consumer
//            d_wr_en, d_wa, d_lat                                - D producer
//            d_md_use, d_md_start                                - HI/LO usage
//            exc_req, exc_pc_err                                 - from M
//            stall_pc, stall_d, flush_d, flush_e, flush_m        - controls
//            md_busy, perf_lat_stalls, perf_md_stalls            - status
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int LW         = 2,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 34
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          d_valid,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic          d_use_rs,
  input  logic          d_use_rt,
  input  logic          d_is_branch,
  input  logic          d_wr_en,
  input  logic [AW-1:0] d_wa,
  input  logic [LW-1:0] d_lat,
  input  logic          d_md_use,
  input  logic [1:0]    d_md_start,
  input  logic          exc_req,
  input  logic          exc_pc_err,
  output logic          stall_pc,
  output logic          stall_d,
  output logic          flush_d,
  output logic          flush_e,
  output logic          flush_m,
  output logic          md_busy,
  output logic [31:0]   perf_lat_stalls,
  output logic [31:0]   perf_md_stalls
);

  // An entry holds at most d_lat+1, so it needs one bit more than d_lat.
  localparam int SBW   = LW + 1;
  localparam int MDMAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int MDW   = $clog2(MDMAX + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SBW-1:0]   sb_q [NREG];
  logic [SBW-1:0]   sb_d [NREG];
  logic [MDW-1:0]   md_q, md_d;

  logic [SBW-1:0]   rs_cnt, rt_cnt, wr_val;
  logic             haz_rs, haz_rt, op_haz, md_haz, in_run, issue;

  // ---------------------------------------------------------------- hazards
  assign rs_cnt = sb_q[d_rs];
  assign rt_cnt = sb_q[d_rt];
  assign wr_val = SBW'(d_lat) + SBW'(1);

  // A branch resolves in D, so it needs the value already forwardable
  // (entry 0). Other consumers pick it up in E, which gives one cycle of
  // slack (entry <= 1).
  always_comb begin
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    if (d_use_rs && (d_rs != '0))
      haz_rs = d_is_branch ? (rs_cnt != '0) : (rs_cnt > SBW'(1));
    if (d_use_rt && (d_rt != '0))
      haz_rt = d_is_branch ? (rt_cnt != '0) : (rt_cnt > SBW'(1));
  end

  assign op_haz  = haz_rs | haz_rt;
  assign md_busy = (md_q != '0);
  assign md_haz  = d_valid & d_md_use & md_busy;
  assign in_run  = (state_q == ST_RUN);
  assign issue   = d_valid & ~stall_d & ~flush_d;

  // --------------------------------------------------------------- FSM comb
  always_comb begin
    state_d  = state_q;
    stall_d  = 1'b0;
    stall_pc = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall_d  = d_valid & (op_haz | md_haz);
        stall_pc = stall_d;
        flush_e  = stall_d;
        if (exc_req) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // The M instruction keeps its slot on a fetch address error.
        flush_d = 1'b1;
        flush_e = 1'b1;
        flush_m = ~exc_pc_err;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Kills the wrong-path instruction that was fetched during FLUSH.
        flush_d = 1'b1;
        flush_e = 1'b1;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // ------------------------------------------------------- scoreboard next
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      sb_d[i] = sb_q[i];
      if (state_q == ST_FLUSH)
        sb_d[i] = '0;
      else if (issue && d_wr_en && (d_wa == AW'(i)))
        sb_d[i] = wr_val;        // a new producer wins over the countdown
      else if (sb_q[i] != '0)
        sb_d[i] = sb_q[i] - SBW'(1);
    end
    sb_d[0] = '0;                // $0 is never a real producer
  end

  // The HI/LO counter ignores flushes: the divider keeps running regardless.
  always_comb begin
    md_d = md_q;
    if (issue && (d_md_start == 2'b01))
      md_d = MDW'(MUL_CYCLES);
    else if (issue && (d_md_start == 2'b10))
      md_d = MDW'(DIV_CYCLES);
    else if (md_q != '0)
      md_d = md_q - MDW'(1);
  end

  // -------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
      md_q    <= '0;
      for (int i = 0; i < NREG; i++) sb_q[i] <= '0;
    end else begin
      state_q <= state_d;
      md_q    <= md_d;
      for (int i = 0; i < NREG; i++) sb_q[i] <= sb_d[i];
    end
  end

  // ---------------------------------------------------------- perf counters
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lat_q, perf_md_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_lat_q <= '0;
      perf_md_q  <= '0;
    end else begin
      if (d_valid && op_haz && in_run) perf_lat_q <= perf_lat_q + 32'd1;
      if (md_haz && in_run)            perf_md_q  <= perf_md_q + 32'd1;
    end
  end

  assign perf_lat_stalls = perf_lat_q;
  assign perf_md_stalls  = perf_md_q;
`else
  assign perf_lat_stalls = 32'h0;
  assign perf_md_stalls  = 32'h0;
`endif

endmodule
`default_nettype wire
